seq_int_divider: RTL and testbench
==================================

Name: seq_int_divider

Overview:
- Iterative radix-2 restoring integer divider; the division counterpart of the radix-4 Wallace-tree multiplier in the ALU.
- Accepts one operand pair per operation through a start/ready handshake.
- Produces quotient and remainder after a fixed latency.
- Supports signed and unsigned operation, with defined divide-by-zero and overflow results.

Parameters:
- WIDTH, 32, operand, quotient and remainder width in bits (≥4).

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  synchronous active-high reset.
- start_i  input  1  request; sampled only while ready_o=1.
- signed_i  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with start_i.
- dividend_i  input  WIDTH  dividend, sampled with start_i.
- divisor_i  input  WIDTH  divisor, sampled with start_i.
- ready_o  output  1  block idle, can accept start_i.
- valid_o  output  1  one-cycle pulse: results valid.
- quotient_o  output  WIDTH  quotient; held until next valid_o.
- remainder_o  output  WIDTH  remainder; held until next valid_o.
- div_by_zero_o  output  1  set with valid_o when divisor was 0; held with results.

Behaviour:
- Reset: state IDLE, ready_o=1, valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0. Internal counter and working registers are cleared.
- States:
  - IDLE: ready_o=1. start_i=1 at an edge latches operands and signed_i, then goes to PREP.
  - PREP (1 cycle): ready_o=0.
    - Compute absolute values when signed, and latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
    - If divisor==0, go to FIX with zero flag set. Otherwise load the partial remainder with 0 and the shift register with |dividend|, set counter=WIDTH-1, and go to CALC.
  - CALC (WIDTH cycles): each edge performs one restoring step.
    - Shift {rem,quo} left by 1.
    - Compute trial = rem − |divisor| at WIDTH+1 bits.
    - If trial ≥ 0: rem=trial and quotient LSB=1; else quotient LSB=0.
    - When counter==0, go to FIX; otherwise decrement the counter.
  - FIX (1 cycle): apply the sign correction and register the outputs. Set valid_o=1 for the following cycle and return to IDLE, where ready_o=1 in the same cycle valid_o is high.
- Latency: if start_i is sampled at edge k, valid_o is high in the cycle after edge k+WIDTH+2. For WIDTH=32, that is 34 edges.
- Divide-by-zero: skips CALC, so valid_o is high after edge k+2. Results: quotient_o = all ones, remainder_o = original dividend_i, div_by_zero_o=1. These are the same for signed and unsigned.
- Signed overflow (dividend = −2^(WIDTH−1), divisor = −1): quotient_o = −2^(WIDTH−1), remainder_o = 0, div_by_zero_o = 0. This falls out of the unsigned-magnitude datapath; no special case is needed.
- Sign rules (signed_i=1): results truncate toward zero.
  - Quotient is negated if sign_q=1.
  - Remainder is negated if sign_r=1, so it carries the dividend's sign.
  - Unsigned mode: no correction.
- start_i outside IDLE is ignored with no queuing. Operand inputs may change freely after the sampling edge.
- Back-to-back: start_i may be high in the same cycle valid_o is high. It is accepted, and the previous outputs stay stable until the new valid_o.
- rst_i mid-operation aborts immediately and gives the reset values above. No valid_o pulse is produced for the aborted operation.
- div_by_zero_o updates only when valid_o asserts.

Decomposition:
- Shared package alu_div_pkg:
  - state encoding localparams (IDLE, PREP, CALC, FIX).
  - default WIDTH constant.
  - counter width function clog2(WIDTH).
- One sub-module is natural: div_restore_step. It is combinational and computes the shift, trial subtract, select and quotient bit.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is instantiated once inside the CALC datapath, which leaves room for a later unrolled multi-step version.

Test Plan:
- Unsigned 100/7, WIDTH=32, start at edge k → valid_o after edge k+34; quotient=14, remainder=2, div_by_zero_o=0; ready_o low for exactly 34 cycles.
- Signed −100/7 → q=−14 (0xFFFFFFF2), r=−2 (0xFFFFFFFE). Signed 100/−7 → q=−14, r=2.
- Unsigned 0xFFFFFFFF/0x00000001 → q=0xFFFFFFFF, r=0. Signed 0x80000000/0xFFFFFFFF → q=0x80000000, r=0.
- Any dividend 0x12345678 / 0, either mode → valid_o 2 edges after start; q=0xFFFFFFFF, r=0x12345678, div_by_zero_o=1.
- Pulse start_i with 50/5 during CALC of a running 9/4 → only one valid_o, results q=2, r=1; the second request is dropped. Then start back-to-back with valid_o → accepted, and the prior outputs are held.
- Assert rst_i at edge k+10 of an operation → ready_o=1, valid_o=0, all outputs 0 next cycle; no late valid_o appears over the following 40 cycles.

Source files
------------

// File: rtl/alu_div_pkg.sv
// ---------------------------------------------------------------------------
// alu_div_pkg
// Shared definitions for the sequential integer divider.
//   DIV_DEFAULT_WIDTH : default operand / result width in bits
//   div_state_e       : FSM state encoding (IDLE, PREP, CALC, FIX)
//   clog2()           : bit width needed for the step counter
// ---------------------------------------------------------------------------
package alu_div_pkg;

    localparam int unsigned DIV_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIX  = 2'd3
    } div_state_e;

    // Number of bits needed to hold the values 0 .. value-1.
    // Never returns less than 1, so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remaining;
        result    = 0;
        remaining = (value > 0) ? value - 1 : 0;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// ---------------------------------------------------------------------------
// div_restore_step
// One combinational radix-2 restoring division step on unsigned magnitudes.
// The {rem, quo} pair is shifted left by one, the divisor is trial-subtracted
// from the widened partial remainder, and the new quotient bit records
// whether the subtraction was kept.
//
// Ports:
//   rem_i     in  WIDTH  current partial remainder (always < divisor_i)
//   quo_i     in  WIDTH  shift register: remaining dividend bits / quotient
//   divisor_i in  WIDTH  divisor magnitude (non-zero)
//   rem_o     out WIDTH  next partial remainder
//   quo_o     out WIDTH  next shift register value, new quotient bit in LSB
// ---------------------------------------------------------------------------
module div_restore_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             keep;

    // The shifted remainder needs WIDTH+1 bits; the trial difference carries
    // one more bit on top so its MSB is a clean borrow / sign flag. When the
    // subtraction is rejected the shifted value is known to be below the
    // divisor, so dropping its top bit on restore loses nothing.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, divisor_i};
        keep    = ~trial[WIDTH+1];
        rem_o   = keep ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], keep};
    end

endmodule

// File: rtl/seq_int_divider.sv
// ---------------------------------------------------------------------------
// seq_int_divider
// Iterative radix-2 restoring integer divider, signed or unsigned, with a
// start/ready request handshake and a one-cycle valid_o result pulse.
// Latency from an accepted start is WIDTH+2 clock edges (2 for divide by
// zero). Signed results truncate toward zero; the remainder carries the sign
// of the dividend.
//
// Ports:
//   clk_i         in   1      clock, rising edge
//   rst_i         in   1      synchronous active-high reset
//   start_i       in   1      operation request, honoured only when ready_o=1
//   signed_i      in   1      1 = two's-complement operands, 0 = unsigned
//   dividend_i    in   WIDTH  dividend, sampled with start_i
//   divisor_i     in   WIDTH  divisor, sampled with start_i
//   ready_o       out  1      idle, can accept start_i
//   valid_o       out  1      one-cycle pulse, results valid
//   quotient_o    out  WIDTH  quotient, held until the next valid_o
//   remainder_o   out  WIDTH  remainder, held until the next valid_o
//   div_by_zero_o out  1      divisor was zero, held with the results
// ---------------------------------------------------------------------------
module seq_int_divider
    import alu_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned      CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Raw operands as sampled at start; the raw dividend is also the
    // divide-by-zero remainder.
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             signed_mode_q, signed_mode_d;

    // Unsigned-magnitude working state for the iteration.
    logic [WIDTH-1:0] dvsr_abs_q, dvsr_abs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_div_q, zero_div_d;

    // Registered, held outputs.
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    // Operand magnitudes. The most negative value maps onto its own bit
    // pattern, which read as unsigned is exactly its magnitude, so signed
    // overflow needs no special handling further down.
    always_comb begin
        dvd_neg = signed_mode_q & dividend_q[WIDTH-1];
        dvs_neg = signed_mode_q & divisor_q[WIDTH-1];
        dvd_abs = dvd_neg ? -dividend_q : dividend_q;
        dvs_abs = dvs_neg ? -divisor_q : divisor_q;
    end

    div_restore_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvsr_abs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Next-state and datapath control. Every register holds by default and
    // valid only pulses for the single cycle after FIX.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dividend_d    = dividend_q;
        divisor_d     = divisor_q;
        signed_mode_d = signed_mode_q;
        dvsr_abs_d    = dvsr_abs_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        zero_div_d    = zero_div_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        dbz_d         = dbz_q;
        valid_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dividend_d    = dividend_i;
                    divisor_d     = divisor_i;
                    signed_mode_d = signed_i;
                    state_d       = ST_PREP;
                end
            end

            ST_PREP: begin
                neg_quo_d  = dvd_neg ^ dvs_neg;
                neg_rem_d  = dvd_neg;
                dvsr_abs_d = dvs_abs;
                if (divisor_q == '0) begin
                    zero_div_d = 1'b1;
                    state_d    = ST_FIX;
                end else begin
                    zero_div_d = 1'b0;
                    rem_d      = '0;
                    quo_d      = dvd_abs;
                    cnt_d      = CNT_LAST;
                    state_d    = ST_CALC;
                end
            end

            ST_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_FIX: begin
                valid_d = 1'b1;
                state_d = ST_IDLE;
                if (zero_div_q) begin
                    quotient_d  = {WIDTH{1'b1}};
                    remainder_d = dividend_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                    dbz_d       = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register. Reset clears everything, including any operation in
    // flight, so an aborted operation never produces a valid pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dividend_q    <= '0;
            divisor_q     <= '0;
            signed_mode_q <= 1'b0;
            dvsr_abs_q    <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            zero_div_q    <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            dbz_q         <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dividend_q    <= dividend_d;
            divisor_q     <= divisor_d;
            signed_mode_q <= signed_mode_d;
            dvsr_abs_q    <= dvsr_abs_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            zero_div_q    <= zero_div_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            dbz_q         <= dbz_d;
            valid_q       <= valid_d;
        end
    end

    assign ready_o       = (state_q == ST_IDLE);
    assign valid_o       = valid_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_int_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_int_divider
// Directed bench for seq_int_divider at WIDTH=32. Expected results come from
// a 64-bit reference division and are queued when a request is driven, then
// popped when valid_o appears.
// ---------------------------------------------------------------------------
module tb_seq_int_divider;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rstIn = 1'b1;
    logic         startIn = 1'b0;
    logic         signedIn = 1'b0;
    logic [W-1:0] dividendIn = '0;
    logic [W-1:0] divisorIn = '0;
    logic         ready_o;
    logic         valid_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;
    logic         div_by_zero_o;

    exp_t sbQueue[$];
    int   nVec = 0;
    int   nErr = 0;

    seq_int_divider #(
        .WIDTH(W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rstIn),
        .start_i       (startIn),
        .signed_i      (signedIn),
        .dividend_i    (dividendIn),
        .divisor_i     (divisorIn),
        .ready_o       (ready_o),
        .valid_o       (valid_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nErr++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference division in 64-bit arithmetic, where the most negative
    // dividend over -1 cannot overflow; its low 32 bits give the wrapped result.
    function automatic exp_t modelDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            return e;
        end
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        qq    = sa / sb;
        rr    = sa % sb;
        e.q   = qq[W-1:0];
        e.r   = rr[W-1:0];
        e.dbz = 1'b0;
        return e;
    endfunction

    // Present one request for a single edge, then scramble the operand pins.
    task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit doPush);
        signedIn   = sgn;
        dividendIn = a;
        divisorIn  = b;
        startIn    = 1'b1;
        if (doPush) sbQueue.push_back(modelDiv(sgn, a, b));
        tick();
        startIn    = 1'b0;
        dividendIn = $urandom;
        divisorIn  = $urandom;
        signedIn   = $urandom_range(0, 1) == 1;
    endtask

    // Wait (bounded) for valid_o, check latency counted from the accepting
    // edge, then compare against the scoreboard head.
    task automatic waitResult(input string tag, input int expLat, input int elapsed, output int lowCnt);
        int   lat;
        bit   seen;
        exp_t e;
        lat    = elapsed;
        seen   = 1'b0;
        lowCnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            lat++;
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            if (!ready_o) lowCnt++;
        end
        checkOutput({tag, "_valid_seen"}, W'(seen), W'(1));
        if (!seen) return;
        checkOutput({tag, "_latency"}, W'(lat), W'(expLat));
        checkOutput({tag, "_ready_at_valid"}, W'(ready_o), W'(1));
        checkOutput({tag, "_sb_nonempty"}, W'(sbQueue.size() > 0), W'(1));
        if (sbQueue.size() == 0) return;
        e = sbQueue.pop_front();
        checkOutput({tag, "_quotient"}, quotient_o, e.q);
        checkOutput({tag, "_remainder"}, remainder_o, e.r);
        checkOutput({tag, "_dbz"}, W'(div_by_zero_o), W'(e.dbz));
    endtask

    task automatic countQuiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (valid_o) pulses++;
        end
        checkOutput(tag, W'(pulses), W'(0));
    endtask

    initial begin : stimulus
        int          low;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        $display("[TB] seq_int_divider bench start");

        repeat (3) tick();
        rstIn = 1'b0;
        checkOutput("reset_ready", W'(ready_o), W'(1));
        checkOutput("reset_valid", W'(valid_o), W'(0));
        checkOutput("reset_quotient", quotient_o, '0);
        checkOutput("reset_remainder", remainder_o, '0);
        checkOutput("reset_dbz", W'(div_by_zero_o), W'(0));

        // Unsigned 100/7: 34-edge latency, ready low for 34 cycles.
        applyStimulus(1'b0, 32'd100, 32'd7, 1'b1);
        checkOutput("u100_7_ready_low_now", W'(ready_o), W'(0));
        waitResult("u100_7", 34, 0, low);
        checkOutput("u100_7_ready_low_cycles", W'(low + 1), W'(34));
        checkOutput("u100_7_q_const", quotient_o, 32'd14);
        checkOutput("u100_7_r_const", remainder_o, 32'd2);
        tick();
        checkOutput("u100_7_valid_one_cycle", W'(valid_o), W'(0));
        checkOutput("u100_7_q_held", quotient_o, 32'd14);

        // Signed sign rules and the wide/overflow corners.
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
        waitResult("s_m100_7", 34, 0, low);
        checkOutput("s_m100_7_q_const", quotient_o, 32'hFFFF_FFF2);
        checkOutput("s_m100_7_r_const", remainder_o, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 32'd100, 32'hFFFF_FFF9, 1'b1);
        waitResult("s_100_m7", 34, 0, low);
        checkOutput("s_100_m7_r_const", remainder_o, 32'd2);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
        waitResult("u_max_1", 34, 0, low);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        waitResult("s_overflow", 34, 0, low);
        checkOutput("s_overflow_q_const", quotient_o, 32'h8000_0000);

        // A request during CALC is dropped: one result only.
        applyStimulus(1'b0, 32'd9, 32'd4, 1'b1);
        repeat (5) tick();
        applyStimulus(1'b0, 32'd50, 32'd5, 1'b0);
        waitResult("ignore_9_4", 34, 6, low);
        checkOutput("ignore_q_const", quotient_o, 32'd2);
        countQuiet("ignore_no_extra_valid", 40);
        checkOutput("ignore_sb_empty", W'(sbQueue.size()), W'(0));

        // A few random operand pairs in both modes.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb = rb >> $urandom_range(0, 28);
            applyStimulus(i[0], ra, rb, 1'b1);
            waitResult("random", (rb == '0) ? 2 : 34, 0, low);
        end

        // Back-to-back start in the valid cycle; prior results stay held.
        applyStimulus(1'b0, 32'd1000, 32'd3, 1'b1);
        waitResult("b2b_first", 34, 0, low);
        applyStimulus(1'b0, 32'd77, 32'd10, 1'b1);
        checkOutput("b2b_accepted", W'(ready_o), W'(0));
        checkOutput("b2b_q_held", quotient_o, 32'd333);
        repeat (10) tick();
        checkOutput("b2b_r_held", remainder_o, 32'd1);
        waitResult("b2b_second", 34, 10, low);

        // Divide by zero in both modes: skips CALC.
        applyStimulus(1'b0, 32'h1234_5678, 32'd0, 1'b1);
        waitResult("dbz_unsigned", 2, 0, low);
        checkOutput("dbz_u_r_const", remainder_o, 32'h1234_5678);
        applyStimulus(1'b1, 32'h1234_5678, 32'd0, 1'b1);
        waitResult("dbz_signed", 2, 0, low);
        applyStimulus(1'b1, 32'h8765_4321, 32'd0, 1'b1);
        waitResult("dbz_signed_neg", 2, 0, low);
        checkOutput("dbz_neg_flag_const", W'(div_by_zero_o), W'(1));

        // Reset at edge k+10 aborts the operation with no late valid.
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0);
        repeat (9) tick();
        rstIn = 1'b1;
        tick();
        rstIn = 1'b0;
        checkOutput("abort_ready", W'(ready_o), W'(1));
        checkOutput("abort_valid", W'(valid_o), W'(0));
        checkOutput("abort_quotient", quotient_o, '0);
        checkOutput("abort_remainder", remainder_o, '0);
        checkOutput("abort_dbz", W'(div_by_zero_o), W'(0));
        countQuiet("abort_no_late_valid", 40);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
